// File: rtl/sync_gray_ptr.sv
// Gray-coded pointer synchronizer for async FIFO crossings, with binary conversion,
// change strobe and illegal-transition detection. Define SYNC_ERR_CNT_EN to add err_cnt_o.
module sync_gray_ptr #(
    parameter int unsigned PTR_WIDTH = 4,
    parameter int unsigned SYNC      = 2,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PTR_WIDTH-1:0] data_i,
    input  logic                 err_clr_i,
    output logic [PTR_WIDTH-1:0] ptr_gray_o,
    output logic [PTR_WIDTH-1:0] ptr_bin_o,
    output logic                 changed_o,
    output logic                 err_o
`ifdef SYNC_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

    localparam int unsigned C_SYNC = (SYNC < 2) ? 2 : SYNC;

    if (PTR_WIDTH < 2 || PTR_WIDTH > 16 || ERR_CNT_W < 1) begin : g_bad_param
        $error("sync_gray_ptr: PTR_WIDTH must be 2..16 and ERR_CNT_W at least 1");
    end

    logic [PTR_WIDTH-1:0] sync_q [C_SYNC];
    logic [PTR_WIDTH-1:0] g_s;
    logic [PTR_WIDTH-1:0] bin_c;
    logic [PTR_WIDTH-1:0] diff_c;
    logic                 illegal_c;

    // Plain flop chain: no logic between stages so each bit resolves independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < C_SYNC; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= data_i;
            for (int unsigned i = 1; i < C_SYNC; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign g_s = sync_q[C_SYNC-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_c                = '0;
        bin_c[PTR_WIDTH-1]   = g_s[PTR_WIDTH-1];
        for (int i = int'(PTR_WIDTH) - 2; i >= 0; i--) begin
            bin_c[i] = bin_c[i+1] ^ g_s[i];
        end
    end

    // More than one bit set in the difference means a non-Gray step.
    assign diff_c    = g_s ^ ptr_gray_o;
    assign illegal_c = (diff_c & (diff_c - PTR_WIDTH'(1))) != '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_gray_o <= '0;
            ptr_bin_o  <= '0;
            changed_o  <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            ptr_gray_o <= g_s;
            ptr_bin_o  <= bin_c;
            changed_o  <= (diff_c != '0);
            err_o      <= illegal_c | (err_o & ~err_clr_i);
        end
    end

`ifdef SYNC_ERR_CNT_EN
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    // Saturating count; a clear coinciding with a new error leaves a count of one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_o <= '0;
        end else if (err_clr_i) begin
            err_cnt_o <= illegal_c ? ERR_CNT_W'(1) : '0;
        end else if (illegal_c && (err_cnt_o != CNT_MAX)) begin
            err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sync_gray_ptr.sv
// Self-checking bench for sync_gray_ptr: reference model plus directed vectors.
module tb_sync_gray_ptr;

    localparam int W    = 4;
    localparam int NSYN = 2;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  data_i;
    logic          err_clr_i;
    logic [W-1:0]  ptr_gray_o;
    logic [W-1:0]  ptr_bin_o;
    logic          changed_o;
    logic          err_o;
`ifdef SYNC_ERR_CNT_EN
    logic [CW-1:0] err_cnt_o;
`endif

    sync_gray_ptr #(.PTR_WIDTH(W), .SYNC(NSYN), .ERR_CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_i     (data_i),
        .err_clr_i  (err_clr_i),
        .ptr_gray_o (ptr_gray_o),
        .ptr_bin_o  (ptr_bin_o),
        .changed_o  (changed_o),
        .err_o      (err_o)
`ifdef SYNC_ERR_CNT_EN
        ,
        .err_cnt_o  (err_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & ((1 << W) - 1);
    endfunction

    function automatic int to_bin(input int g);
        int b;
        b = g;
        for (int s = 1; s < W; s = s << 1) b = b ^ (b >> s);
        return b & ((1 << W) - 1);
    endfunction

    // Reference model: input samples delayed by the chain depth, then the output rules.
    int pipe[$];
    int m_gray, m_bin, m_changed, m_err, m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe = {};
            for (int i = 0; i < NSYN; i++) pipe.push_back(0);
            m_gray = 0; m_bin = 0; m_changed = 0; m_err = 0; m_cnt = 0;
        end else begin
            int nxt;
            int ill;
            nxt = pipe.pop_front();
            pipe.push_back(int'(data_i));
            ill = ($countones(nxt ^ m_gray) > 1) ? 1 : 0;
            m_changed = (nxt != m_gray) ? 1 : 0;
            m_err = (ill != 0 || (m_err != 0 && !err_clr_i)) ? 1 : 0;
            if (err_clr_i) m_cnt = ill;
            else if (ill != 0 && m_cnt < CMAX) m_cnt = m_cnt + 1;
            m_gray = nxt;
            m_bin  = to_bin(nxt);
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("model_gray", int'(ptr_gray_o), m_gray);
            check("model_bin", int'(ptr_bin_o), m_bin);
            check("model_changed", int'(changed_o), m_changed);
            check("model_err", int'(err_o), m_err);
`ifdef SYNC_ERR_CNT_EN
            check("model_cnt", int'(err_cnt_o), m_cnt);
`endif
            if (changed_o === 1'b1) pulses++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        check({name, "_gray"}, int'(ptr_gray_o), 0);
        check({name, "_bin"}, int'(ptr_bin_o), 0);
        check({name, "_changed"}, int'(changed_o), 0);
        check({name, "_err"}, int'(err_o), 0);
`ifdef SYNC_ERR_CNT_EN
        check({name, "_cnt"}, int'(err_cnt_o), 0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; data_i = '0; err_clr_i = 1'b0;
        #1;
        check_zero("reset");
        step(2);
        rst_n = 1'b1;
        step(3);

        // Gray count sweep through wrap back to zero
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            data_i = W'(to_gray(i % 16));
            step(4);
            check("sweep_bin", int'(ptr_bin_o), i % 16);
        end
        check("sweep_pulses", pulses, 16);
        check("sweep_err", int'(err_o), 0);

        // Single update latency
        data_i = 4'b0001;
        step(2);
        check("single_early", int'(ptr_gray_o), 0);
        step(1);
        check("single_gray", int'(ptr_gray_o), 1);
        check("single_bin", int'(ptr_bin_o), 1);
        check("single_changed", int'(changed_o), 1);
        check("single_err", int'(err_o), 0);
        step(1);
        check("single_strobe_end", int'(changed_o), 0);

        // Illegal jump 0000 -> 0011
        data_i = 4'b0000;
        step(4);
        data_i = 4'b0011;
        step(3);
        check("illegal_gray", int'(ptr_gray_o), 3);
        check("illegal_bin", int'(ptr_bin_o), 2);
        check("illegal_err", int'(err_o), 1);
        step(20);
        check("illegal_sticky", int'(err_o), 1);
`ifdef SYNC_ERR_CNT_EN
        check("illegal_cnt", int'(err_cnt_o), 1);
`endif

        // Clear coinciding with a second illegal jump: set wins
        data_i = 4'b0101;
        step(2);
        err_clr_i = 1'b1;
        step(1);
        err_clr_i = 1'b0;
        check("prio_gray", int'(ptr_gray_o), 5);
        check("prio_err", int'(err_o), 1);
`ifdef SYNC_ERR_CNT_EN
        check("prio_cnt", int'(err_cnt_o), 1);
`endif
        err_clr_i = 1'b1;
        step(1);
        err_clr_i = 1'b0;
        check("clear_err", int'(err_o), 0);
`ifdef SYNC_ERR_CNT_EN
        check("clear_cnt", int'(err_cnt_o), 0);
`endif

        // Five illegal jumps saturate the counter
        for (int k = 0; k < 5; k++) begin
            data_i = (k % 2 == 0) ? 4'b0011 : 4'b0101;
            step(4);
        end
        check("sat_err", int'(err_o), 1);
`ifdef SYNC_ERR_CNT_EN
        check("sat_cnt", int'(err_cnt_o), CMAX);
`endif

        // Mid-run asynchronous reset with a nonzero source pointer held
        err_clr_i = 1'b1;
        step(1);
        err_clr_i = 1'b0;
        data_i = 4'b0110;
        step(4);
        check("pre_rst_gray", int'(ptr_gray_o), 6);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        step(1);
        #2;
        rst_n = 1'b1;
        step(2);
        check("refill_early", int'(ptr_gray_o), 0);
        step(1);
        check("refill_gray", int'(ptr_gray_o), 6);
        check("refill_bin", int'(ptr_bin_o), 4);
        check("refill_changed", int'(changed_o), 1);
        check("refill_err", int'(err_o), 1);
`ifdef SYNC_ERR_CNT_EN
        check("refill_cnt", int'(err_cnt_o), 1);
`endif
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
